// File: rtl/vital_sign_pkg.sv
// Shared channel map, state encoding and helpers for the actuator scheduler.
// DUTY_LIMIT_EN selects the on-time limit / cool-down feature.
package vital_sign_pkg;

   localparam int NUM_HP     = 4;
   localparam int CH_VIB     = 0;
   localparam int CH_FAN     = 1;
   localparam int CH_VALVE   = 2;
   localparam int CH_PUMP    = 3;

   localparam int REQ_BUZZER = 0;
   localparam int REQ_LED    = 1;
   localparam int REQ_HP_LSB = 2;

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_ON_MIN = 2'd1,
      ST_ON     = 2'd2,
      ST_COOL   = 2'd3
   } ch_state_e;

`ifdef DUTY_LIMIT_EN
   localparam bit DUTY_EN = 1'b1;
`else
   localparam bit DUTY_EN = 1'b0;
`endif

   function automatic logic [2:0] popcnt4(input logic [3:0] v);
      popcnt4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

endpackage

// File: rtl/actuator_channel_fsm.sv
// One high-power channel: state, on/cool counter and min-on protection.
// DUTY_LIMIT_EN enables the on-time trip into COOL (not for EXEMPT).
module actuator_channel_fsm
   import vital_sign_pkg::*;
#(
   parameter int MIN_ON_CYCLES = 4,
   parameter int MAX_ON_CYCLES = 64,
   parameter int COOL_CYCLES   = 16,
   parameter int CNT_W         = 8,
   parameter bit EXEMPT        = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_req,
   input  logic i_grant,
   input  logic i_preempt,
   output logic o_is_on,
   output logic o_stay,
   output logic o_can_preempt,
   output logic o_eligible
);

   ch_state_e        r_state;
   ch_state_e        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_min_done;
   logic             w_cool_done;
   logic             w_trip;
   logic             w_on_any;

   assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
   assign w_min_done  = (r_cnt == CNT_W'(MIN_ON_CYCLES - 1));
   assign w_cool_done = (r_cnt == CNT_W'(COOL_CYCLES - 1));
   assign w_on_any    = (r_state == ST_ON_MIN) || (r_state == ST_ON);
   assign w_trip      = DUTY_EN && !EXEMPT && w_on_any
                        && (r_cnt == CNT_W'(MAX_ON_CYCLES - 1));

   // Last min-on cycle already behaves like ON: it may drop or be
   // preempted on the edge it leaves ON_MIN.
   assign o_is_on       = w_on_any;
   assign o_stay        = !w_trip
                          && (((r_state == ST_ON_MIN)
                               && (!w_min_done || i_req))
                              || ((r_state == ST_ON) && i_req));
   assign o_can_preempt = o_stay
                          && ((r_state == ST_ON)
                              || ((r_state == ST_ON_MIN) && w_min_done));
   assign o_eligible    = (r_state == ST_OFF)
                          || ((r_state == ST_COOL) && w_cool_done);

   // Next state and counter.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         ST_OFF: begin
            w_cnt_nxt = '0;
            if (i_grant) w_state_nxt = ST_ON_MIN;
         end
         ST_ON_MIN: begin
            if (w_trip) begin
               w_state_nxt = ST_COOL;
               w_cnt_nxt   = '0;
            end else if (w_min_done) begin
               if (!i_req || i_preempt) begin
                  w_state_nxt = ST_OFF;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = ST_ON;
                  w_cnt_nxt   = w_cnt_inc;
               end
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         ST_ON: begin
            if (w_trip) begin
               w_state_nxt = ST_COOL;
               w_cnt_nxt   = '0;
            end else if (!i_req || i_preempt) begin
               w_state_nxt = ST_OFF;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         ST_COOL: begin
            if (w_cool_done) begin
               w_cnt_nxt   = '0;
               w_state_nxt = i_grant ? ST_ON_MIN : ST_OFF;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_OFF;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

endmodule

// File: rtl/actuator_power_scheduler.sv
// Grants a shared high-power budget to four actuators by priority.
// DUTY_LIMIT_EN adds per-grant on-time limit and cool-down.
module actuator_power_scheduler
   import vital_sign_pkg::*;
#(
   parameter int MAX_ACTIVE    = 2,
   parameter int MIN_ON_CYCLES = 4,
   parameter int MAX_ON_CYCLES = 64,
   parameter int COOL_CYCLES   = 16,
   parameter int CNT_W         = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] req_in,
   output logic       Buzzer,
   output logic       LED,
   output logic       Vibrator,
   output logic       Micro_Fan,
   output logic       Selenoid_Valve,
   output logic       Infuse_Pump,
   output logic [3:0] pending,
   output logic [2:0] active_cnt
);

   logic [NUM_HP-1:0] w_req;
   logic [NUM_HP-1:0] w_is_on;
   logic [NUM_HP-1:0] w_stay;
   logic [NUM_HP-1:0] w_can_pre;
   logic [NUM_HP-1:0] w_elig;
   logic [NUM_HP-1:0] w_grant;
   logic [NUM_HP-1:0] w_preempt;
   logic [NUM_HP-1:0] w_wait;
   logic [NUM_HP-1:0] w_next_on;
   logic [2:0]        w_free;
   logic [2:0]        w_used;
   logic [1:0]        w_hi;
   logic [1:0]        w_vic;
   logic              w_hi_vld;
   logic              w_vic_vld;

   logic              r_buzzer;
   logic              r_led;
   logic [3:0]        r_pending;
   logic [2:0]        r_active_cnt;

   assign w_req = req_in[REQ_HP_LSB +: NUM_HP];

   for (genvar g = 0; g < NUM_HP; g++) begin : g_ch
      actuator_channel_fsm #(
         .MIN_ON_CYCLES (MIN_ON_CYCLES),
         .MAX_ON_CYCLES (MAX_ON_CYCLES),
         .COOL_CYCLES   (COOL_CYCLES),
         .CNT_W         (CNT_W),
         .EXEMPT        (g == CH_PUMP)
      ) u_ch (
         .clk           (clk),
         .reset         (reset),
         .i_req         (w_req[g]),
         .i_grant       (w_grant[g]),
         .i_preempt     (w_preempt[g]),
         .o_is_on       (w_is_on[g]),
         .o_stay        (w_stay[g]),
         .o_can_preempt (w_can_pre[g]),
         .o_eligible    (w_elig[g])
      );
   end

   // Fill free slots top-down, then at most one preemption.
   always_comb begin
      w_grant   = '0;
      w_preempt = '0;
      w_wait    = '0;
      w_used    = '0;
      w_hi      = '0;
      w_hi_vld  = 1'b0;
      w_vic     = '0;
      w_vic_vld = 1'b0;
      w_free    = 3'(MAX_ACTIVE) - popcnt4(w_stay);
      for (int i = NUM_HP - 1; i >= 0; i--) begin
         if (w_elig[i] && w_req[i]) begin
            if (w_used < w_free) begin
               w_grant[i] = 1'b1;
               w_used     = w_used + 3'd1;
            end else begin
               w_wait[i] = 1'b1;
            end
         end
      end
      for (int i = 0; i < NUM_HP; i++) begin
         if (w_wait[i]) begin
            w_hi     = 2'(i);
            w_hi_vld = 1'b1;
         end
      end
      for (int i = NUM_HP - 1; i >= 0; i--) begin
         if (w_can_pre[i]) begin
            w_vic     = 2'(i);
            w_vic_vld = 1'b1;
         end
      end
      if (w_hi_vld && w_vic_vld && (w_vic < w_hi)) begin
         w_preempt[w_vic] = 1'b1;
         w_grant[w_hi]    = 1'b1;
      end
   end

   assign w_next_on = (w_stay & ~w_preempt) | w_grant;

   // Low-power pass-through, pending and slot count registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_buzzer     <= 1'b0;
         r_led        <= 1'b0;
         r_pending    <= '0;
         r_active_cnt <= '0;
      end else begin
         r_buzzer     <= req_in[REQ_BUZZER];
         r_led        <= req_in[REQ_LED];
         r_pending    <= w_req & ~w_next_on;
         r_active_cnt <= popcnt4(w_next_on);
      end
   end

   assign Buzzer         = r_buzzer;
   assign LED            = r_led;
   assign Vibrator       = w_is_on[CH_VIB];
   assign Micro_Fan      = w_is_on[CH_FAN];
   assign Selenoid_Valve = w_is_on[CH_VALVE];
   assign Infuse_Pump    = w_is_on[CH_PUMP];
   assign pending        = r_pending;
   assign active_cnt     = r_active_cnt;

endmodule
